data_out_uart: RTL

DATA_OUT_UART -- requirements
Module: data_out_uart

---
 rtl/data_out_uart_pkg.sv | 16 +
 rtl/byte_fifo.sv | 67 ++++++
 rtl/data_out_uart.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/data_out_uart_pkg.sv
// Shared types and frame constants for the byte-stream UART transmitter.
// No logic and no latency; this package only carries definitions.
package data_out_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with first-word-fall-through head; pointers carry one extra wrap bit.
// Latency: a pushed byte is visible on head_dat_o the cycle after the push edge.
// Backpressure: a push while full is accepted only with a same-edge pop, otherwise dropped and flagged.
module byte_fifo
    import data_out_uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_vld_i,
    input  logic [DATA_BITS-1:0] push_dat_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] head_dat_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic                 do_push;
    logic                 do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop on the same edge frees the slot a full-FIFO push needs.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_vld_i && (!full_o || do_pop);
    assign drop_o  = push_vld_i && !do_push;

    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/data_out_uart.sv
// Buffered 8N1 UART transmitter for core output bytes; DATA_OUT_CHANGE_FILTER_EN enqueues on data change instead of we_i.
// Latency: a write into an empty idle buffer starts the start bit two edges later; frames run back-to-back.
// Backpressure: none upstream; bytes written while the buffer is full are dropped and overflow_o sticks high.
module data_out_uart
    import data_out_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    input  logic       we_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       full_o,
    output logic       overflow_o
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    logic [1:0]           rst_sync_q;
    logic                 rst_int_n;

    uart_state_t          state_q, state_d;
    logic [15:0]          baud_q, baud_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q, ovf_d;

    logic                 push_vld;
    logic                 pop;
    logic                 baud_end;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_drop;

    // Reset asserts immediately but leaves the core two edges after rst_ni rises.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

`ifdef DATA_OUT_CHANGE_FILTER_EN
    logic [7:0] last_q;
    logic       unused_we;

    assign unused_we = we_i;
    assign push_vld  = (data_i != last_q);

    // Only an accepted byte becomes the new reference, so a dropped change retries.
    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            last_q <= 8'h00;
        end else if (push_vld && !fifo_drop) begin
            last_q <= data_i;
        end
    end
`else
    assign push_vld = we_i;
`endif

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_int_n),
        .push_vld_i (push_vld),
        .push_dat_i (data_i),
        .pop_i      (pop),
        .head_dat_o (fifo_head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .drop_o     (fifo_drop)
    );

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = STOP_BIT;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = '0;
                    tx_d    = START_BIT;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        tx_d    = STOP_BIT;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        tx_d    = START_BIT;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = STOP_BIT;
            end
        endcase
    end

    assign ovf_d = ovf_q | fifo_drop;

    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= STOP_BIT;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = (state_q != IDLE) || !fifo_empty;
    assign full_o     = fifo_full;
    assign overflow_o = ovf_q;

endmodule
